// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer with valid/ready input handshake.
// Emits one WIDTH-bit word per WIDTH cycles on x, gap-free when words are chained.
module piso_bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_shift;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             x_q;
    logic             x_d;
    logic             xv_q;
    logic             xv_d;
    logic             at_last;
    logic             accept;

    assign at_last   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign din_ready = !rst && ((state_q == IDLE) || at_last);
    assign accept    = din_valid && din_ready;

    // Shift toward the output end so the next bit always sits at a fixed position.
    assign sr_shift  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last && !accept) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        x_d   = IDLE_LEVEL;
        xv_d  = 1'b0;
        if (accept) begin
            sr_d  = din;
            cnt_d = '0;
            x_d   = MSB_FIRST ? din[WIDTH-1] : din[0];
            xv_d  = 1'b1;
        end else if ((state_q == SHIFT) && !at_last) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CW'(1);
            x_d   = MSB_FIRST ? sr_shift[WIDTH-1] : sr_shift[0];
            xv_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            x_q   <= IDLE_LEVEL;
            xv_q  <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            x_q   <= x_d;
            xv_q  <= xv_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign x_last  = at_last;
    assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: queue-based bit-stream reference model,
// one MSB-first instance (idle 0) and one LSB-first instance (idle 1).
module tb_piso_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din_a = '0;
    logic [W-1:0] din_b = '0;
    logic         v_a = 1'b0;
    logic         v_b = 1'b0;
    logic         rdy_a, x_a, xv_a, xl_a, bz_a;
    logic         rdy_b, x_b, xv_b, xl_b, bz_b;

    int errors = 0;
    int checks = 0;

    // Each entry is {last, bit}; the head is the bit currently on x.
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    bit         acc_a;
    bit         acc_b;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(v_a), .din_ready(rdy_a),
        .x(x_a), .x_valid(xv_a), .x_last(xl_a), .busy(bz_a)
    );

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(v_b), .din_ready(rdy_b),
        .x(x_b), .x_valid(xv_b), .x_last(xl_b), .busy(bz_b)
    );

    function automatic logic [4:0] exp_a();
        if (qa.size() == 0) return {1'b0, 1'b0, 1'b0, 1'b0, !rst};
        return {qa[0][0], 1'b1, qa[0][1], 1'b1, !rst && (qa.size() == 1)};
    endfunction

    function automatic logic [4:0] exp_b();
        if (qb.size() == 0) return {1'b1, 1'b0, 1'b0, 1'b0, !rst};
        return {qb[0][0], 1'b1, qb[0][1], 1'b1, !rst && (qb.size() == 1)};
    endfunction

    function automatic logic [4:0] obs_a();
        return {x_a, xv_a, xl_a, bz_a, rdy_a};
    endfunction

    function automatic logic [4:0] obs_b();
        return {x_b, xv_b, xl_b, bz_b, rdy_b};
    endfunction

    // Advance one clock and update the model with the inputs seen at that edge.
    task automatic step();
        bit ra;
        bit rb;
        @(posedge clk);
        ra    = !rst && (qa.size() <= 1);
        rb    = !rst && (qb.size() <= 1);
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0) void'(qa.pop_front());
            if (qb.size() > 0) void'(qb.pop_front());
            if (v_a && ra) begin
                acc_a = 1'b1;
                for (int i = 0; i < W; i++) qa.push_back({i == W - 1, din_a[W-1-i]});
            end
            if (v_b && rb) begin
                acc_b = 1'b1;
                for (int i = 0; i < W; i++) qb.push_back({i == W - 1, din_b[i]});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        v_a   = 1'b1;
        din_a = W'($urandom);
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (obs_a() !== exp_a() || rdy_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", c, obs_a(), exp_a());
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs_a() !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", obs_a(), 5'b00001);
        end
        v_a = 1'b0;
        step();
        checks++;
        if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=%b", obs_a(), exp_a());
        end
    endtask

    task automatic test_single();
        logic [W-1:0] got;
        got   = '0;
        din_a = 8'b1001_0010;
        v_a   = 1'b1;
        step();
        v_a = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL single bit=%0d got=%b exp=%b", i, obs_a(), exp_a());
            end
            got = {got[W-2:0], x_a};
            step();
        end
        checks++;
        if (obs_a() !== 5'b00001) begin
            errors++;
            $display("FAIL single_end got=%b exp=%b", obs_a(), 5'b00001);
        end
        checks++;
        if (got !== 8'b1001_0010) begin
            errors++;
            $display("FAIL single_seq got=%b exp=%b", got, 8'b1001_0010);
        end
    endtask

    task automatic test_back_to_back();
        int            n_acc;
        int            n_val;
        int            n_rdy;
        logic [15:0]   got;
        n_acc = 0;
        n_val = 0;
        n_rdy = 0;
        got   = '0;
        din_a = 8'hFF;
        v_a   = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            if (acc_a) begin
                n_acc++;
                if (n_acc == 1) din_a = 8'h00;
                else v_a = 1'b0;
            end
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, obs_a(), exp_a());
            end
            if (xv_a) begin
                n_val++;
                got = {got[14:0], x_a};
                if (rdy_a) n_rdy++;
            end
        end
        checks++;
        if (n_val != 16 || got !== 16'hFF00 || n_rdy != 2) begin
            errors++;
            $display("FAIL b2b_stream valid=%0d bits=%h ready=%0d exp 16 ff00 2",
                     n_val, got, n_rdy);
        end
    endtask

    task automatic test_backpressure();
        int           k;
        logic [W-1:0] got;
        got   = '0;
        din_a = W'($urandom);
        v_a   = 1'b1;
        step();
        v_a = 1'b0;
        step();
        step();
        din_a = 8'hA5;
        v_a   = 1'b1;
        k     = 0;
        do begin
            step();
            k++;
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL bp_wait k=%0d got=%b exp=%b", k, obs_a(), exp_a());
            end
        end while (!acc_a && k < 12);
        v_a = 1'b0;
        checks++;
        if (!acc_a || k != 6) begin
            errors++;
            $display("FAIL bp_accept edges=%0d accepted=%0d exp 6 1", k, acc_a);
        end
        for (int i = 0; i < W; i++) begin
            got = {got[W-2:0], x_a};
            step();
        end
        checks++;
        if (got !== 8'hA5 || obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL bp_word got=%h exp=%h", got, 8'hA5);
        end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] got;
        got   = '0;
        din_b = 8'b0000_0001;
        v_b   = 1'b1;
        step();
        v_b = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_b() !== exp_b()) begin
                errors++;
                $display("FAIL lsb bit=%0d got=%b exp=%b", i, obs_b(), exp_b());
            end
            got = {got[W-2:0], x_b};
            step();
        end
        checks++;
        if (got !== 8'b1000_0000 || obs_b() !== 5'b10001) begin
            errors++;
            $display("FAIL lsb_seq got=%b exp=%b", got, 8'b1000_0000);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] got;
        got   = '0;
        din_a = 8'hF0;
        v_a   = 1'b1;
        step();
        v_a = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (obs_a() !== 5'b00000 || obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b", obs_a(), 5'b00000);
        end
        rst   = 1'b0;
        din_a = 8'h81;
        v_a   = 1'b1;
        step();
        v_a = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (obs_a() !== exp_a()) begin
                errors++;
                $display("FAIL mid_next bit=%0d got=%b exp=%b", i, obs_a(), exp_a());
            end
            got = {got[W-2:0], x_a};
            step();
        end
        checks++;
        if (got !== 8'h81) begin
            errors++;
            $display("FAIL mid_next_seq got=%h exp=%h", got, 8'h81);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            v_a   = ($urandom_range(0, 3) != 0);
            v_b   = ($urandom_range(0, 2) == 0);
            din_a = W'($urandom);
            din_b = W'($urandom);
            step();
            checks++;
            if (obs_a() !== exp_a() || obs_b() !== exp_b()) begin
                errors++;
                $display("FAIL random cyc=%0d a=%b/%b b=%b/%b",
                         c, obs_a(), exp_a(), obs_b(), exp_b());
            end
        end
        rst = 1'b0;
        v_a = 1'b0;
        v_b = 1'b0;
        for (int c = 0; c < W + 1; c++) step();
        checks++;
        if (obs_a() !== exp_a() || obs_b() !== exp_b()) begin
            errors++;
            $display("FAIL random_drain a=%b/%b b=%b/%b",
                     obs_a(), exp_a(), obs_b(), exp_b());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_lsb_first();
        test_reset_mid_word();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
